// File: rtl/hazard_scoreboard_if.sv
// ID-stage view of the hazard scoreboard: instruction fields and pipeline
// controls in, hazard flags and per-register busy vector out.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 3
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_writes;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [LAT_W-1:0]      id_lat;
    logic                  hold;
    logic                  flush;
    logic                  stall;
    logic                  raw_hazard;
    logic                  waw_hazard;
    logic [NUM_REGS-1:0]   busy;

    // Pipeline side: drives the instruction in ID, observes the verdict.
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_writes, id_rd, id_lat, hold, flush,
        input  stall, raw_hazard, waw_hazard, busy
    );

    // Scoreboard side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_writes, id_rd, id_lat, hold, flush,
        output stall, raw_hazard, waw_hazard, busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard beside ID. Each register holds a down-counter
// of cycles left until its in-flight result is forwardable; the instruction in
// ID stalls on a pending source (RAW) or on a pending destination that would
// complete no earlier than the new write (WAW). Zero-latency writers are never
// tracked since forwarding already covers them.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 3
) (
    input logic             clk,
    input logic             rst,
    hazard_scoreboard_if.slave sb
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [LAT_W-1:0] cnt [NUM_REGS];

    logic active;
    logic raw_hazard;
    logic waw_hazard;
    logic stall;
    logic issue;
    logic [LAT_W-1:0] cnt_rs;
    logic [LAT_W-1:0] cnt_rt;
    logic [LAT_W-1:0] cnt_rd;

    // Hazard evaluation: purely combinational from ID fields and counters.
    always_comb begin
        active = sb.id_valid && !sb.flush;
        cnt_rs = cnt[sb.id_rs];
        cnt_rt = cnt[sb.id_rt];
        cnt_rd = cnt[sb.id_rd];
        raw_hazard = active &&
                     ((sb.id_uses_rs && (sb.id_rs != '0) && (cnt_rs != '0)) ||
                      (sb.id_uses_rt && (sb.id_rt != '0) && (cnt_rt != '0)));
        // A new write with a longer latency naturally completes after the
        // pending one, so only an equal-or-shorter latency is a conflict.
        waw_hazard = active && sb.id_writes && (sb.id_rd != '0) &&
                     (cnt_rd != '0) && (cnt_rd >= sb.id_lat);
        stall = raw_hazard || waw_hazard;
        issue = active && !stall && !sb.hold && sb.id_writes &&
                (sb.id_rd != '0) && (sb.id_lat != '0);
    end

    assign sb.raw_hazard = raw_hazard;
    assign sb.waw_hazard = waw_hazard;
    assign sb.stall      = stall;

    // Busy vector is a direct decode of the counters.
    always_comb begin
        sb.busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            sb.busy[r] = (cnt[r] != '0);
        end
    end

    // Counter update: reset/flush clear, hold freezes, otherwise load on issue
    // (issue beats decrement on the same register) and count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (sb.flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (!sb.hold) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r == 0) begin
                    cnt[r] <= '0;
                end else if (issue && (sb.id_rd == REG_ADDR_W'(r))) begin
                    cnt[r] <= sb.id_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios from the design intent
// followed by randomized instruction streams, all checked against an
// array-of-integers reference model of remaining latency per register.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if sb_if ();
    hazard_scoreboard dut (.clk(clk), .rst(rst), .sb(sb_if));

    int cnt_m [32];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_raw();
        bit a = sb_if.id_valid && !sb_if.flush;
        bit r1 = sb_if.id_uses_rs && sb_if.id_rs != 0 && cnt_m[sb_if.id_rs] > 0;
        bit r2 = sb_if.id_uses_rt && sb_if.id_rt != 0 && cnt_m[sb_if.id_rt] > 0;
        return a && (r1 || r2);
    endfunction

    function automatic bit m_waw();
        int c = cnt_m[sb_if.id_rd];
        return sb_if.id_valid && !sb_if.flush && sb_if.id_writes &&
               sb_if.id_rd != 0 && c > 0 && c >= int'(sb_if.id_lat);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 0; r < 32; r++) b[r] = (cnt_m[r] > 0);
        return b;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_raw"},   64'(sb_if.raw_hazard), 64'(m_raw()));
        check({tag, "_waw"},   64'(sb_if.waw_hazard), 64'(m_waw()));
        check({tag, "_stall"}, 64'(sb_if.stall),      64'(m_raw() || m_waw()));
        check({tag, "_busy"},  64'(sb_if.busy),       64'(m_busy()));
    endtask

    task automatic model_edge();
        bit iss;
        iss = sb_if.id_valid && !sb_if.flush && !(m_raw() || m_waw()) && !sb_if.hold &&
              sb_if.id_writes && sb_if.id_rd != 0 && sb_if.id_lat != 0;
        if (sb_if.flush) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        end else if (!sb_if.hold) begin
            for (int r = 0; r < 32; r++) begin
                if (iss && r == int'(sb_if.id_rd)) cnt_m[r] = int'(sb_if.id_lat);
                else if (cnt_m[r] > 0) cnt_m[r] = cnt_m[r] - 1;
            end
        end
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit w, input int rd, input int lat, input bit h, input bit f);
        sb_if.id_valid   = v;
        sb_if.id_rs      = 5'(rs);
        sb_if.id_rt      = 5'(rt);
        sb_if.id_uses_rs = urs;
        sb_if.id_uses_rt = urt;
        sb_if.id_writes  = w;
        sb_if.id_rd      = 5'(rd);
        sb_if.id_lat     = 3'(lat);
        sb_if.hold       = h;
        sb_if.flush      = f;
        #1;
    endtask

    task automatic step(input string tag);
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Issue a producer in one cycle: ID holds it across the edge.
    task automatic issue_op(input int rd, input int lat);
        drive(1, 0, 0, 0, 0, 1, rd, lat, 0, 0);
        step("iss");
    endtask

    initial begin
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_busy",  64'(sb_if.busy),  64'd0);
        check("rst_stall", 64'(sb_if.stall), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Load-use through rs, then through rt, then an unrelated reader.
        issue_op(5, 1);
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        check("lu_rs_stall1", 64'(sb_if.stall), 64'd1);
        step("lu_rs");
        check("lu_rs_stall0", 64'(sb_if.stall), 64'd0);
        step("lu_rs");
        issue_op(5, 1);
        drive(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        check("lu_rt_stall1", 64'(sb_if.stall), 64'd1);
        step("lu_rt");
        check("lu_rt_stall0", 64'(sb_if.stall), 64'd0);
        issue_op(5, 1);
        drive(1, 6, 7, 1, 1, 0, 0, 0, 0, 0);
        check("lu_unrel", 64'(sb_if.stall), 64'd0);
        step("lu_unrel");
        check("lu_unrel2", 64'(sb_if.stall), 64'd0);
        step("lu_unrel");

        // Multi-cycle producer with latency 4.
        issue_op(9, 4);
        drive(1, 0, 9, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("mc_raw1",  64'(sb_if.raw_hazard), 64'd1);
            check("mc_busy1", 64'(sb_if.busy[9]),    64'd1);
            step("mc");
        end
        check("mc_raw0",  64'(sb_if.raw_hazard), 64'd0);
        check("mc_busy0", 64'(sb_if.busy[9]),    64'd0);
        step("mc");

        // Register zero is never tracked.
        issue_op(0, 3);
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        check("r0_busy",  64'(sb_if.busy),  64'd0);
        check("r0_stall", 64'(sb_if.stall), 64'd0);
        step("r0");

        // WAW: shorter write waits out the pending one; longer one proceeds.
        issue_op(3, 4);
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("waw_short1", 64'(sb_if.waw_hazard), 64'd1);
            step("waw_s");
        end
        check("waw_short0", 64'(sb_if.waw_hazard), 64'd0);
        step("waw_s");
        issue_op(3, 4);
        drive(1, 0, 0, 0, 0, 1, 3, 5, 0, 0);
        check("waw_long", 64'(sb_if.stall), 64'd0);
        step("waw_l");
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("waw_reload", 64'(sb_if.stall), 64'd1);
            step("waw_r");
        end
        check("waw_reload0", 64'(sb_if.stall), 64'd0);
        step("waw_r");

        // Hold freezes counters; flush clears them.
        issue_op(4, 2);
        drive(1, 4, 0, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            check("hold_busy",  64'(sb_if.busy[4]), 64'd1);
            check("hold_stall", 64'(sb_if.stall),   64'd1);
            step("hold");
        end
        drive(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check("hold_rel", 64'(sb_if.stall), 64'd1);
            step("hold_r");
        end
        check("hold_done", 64'(sb_if.stall), 64'd0);
        step("hold_d");
        issue_op(4, 2);
        drive(1, 4, 0, 1, 0, 0, 0, 0, 0, 1);
        check("flush_stall", 64'(sb_if.stall), 64'd0);
        step("flush");
        drive(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
        check("flush_busy", 64'(sb_if.busy), 64'd0);
        step("flush_a");

        // Asynchronous reset between edges.
        issue_op(8, 3);
        drive(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        check("ar_pre", 64'(sb_if.stall), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("ar_busy",  64'(sb_if.busy),  64'd0);
        check("ar_stall", 64'(sb_if.stall), 64'd0);
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        check("ar_post", 64'(sb_if.stall), 64'd0);
        step("ar");

        // Randomized stream over a small register window to force conflicts.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(7) != 0,
                  $urandom_range(7), $urandom_range(7),
                  $urandom_range(1), $urandom_range(1),
                  $urandom_range(1), $urandom_range(7), $urandom_range(7),
                  $urandom_range(7) == 0, $urandom_range(20) == 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register scoreboard that generalises load-use stall detection to any producer with a fixed result latency: loads, multi-cycle multiply/divide, and future long-latency units. It sits beside the ID stage. It records, per architectural register, how many cycles remain before an in-flight result can be forwarded. It stalls the instruction in ID on read-after-write or write-after-write conflicts. Zero-latency producers (ALU ops covered by forwarding) are never tracked.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W (derived, not overridable)
- LAT_W, 3, latency field width; maximum tracked latency 2**LAT_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_ADDR_W  first source register
- id_rt  in  REG_ADDR_W  second source register
- id_uses_rs  in  1  instruction reads id_rs
- id_uses_rt  in  1  instruction reads id_rt
- id_writes  in  1  instruction writes id_rd
- id_rd  in  REG_ADDR_W  destination register
- id_lat  in  LAT_W  bubbles a dependent adjacent instruction needs (load=1, mul=4, ALU=0)
- hold  in  1  pipeline frozen by a downstream stall; scoreboard freezes
- flush  in  1  ID/EX contents squashed
- stall  out  1  raw_hazard | waw_hazard
- raw_hazard  out  1  source operand pending
- waw_hazard  out  1  destination pending with conflicting completion
- busy  out  NUM_REGS  bit r = (cnt[r] != 0)

## Operation
- State: one LAT_W-bit down-counter cnt[r] per register; cnt[0] is constant 0.
- Combinational outputs, all forced 0 when !id_valid or flush:
  - raw_hazard = (id_uses_rs && id_rs!=0 && cnt[id_rs]!=0) || (id_uses_rt && id_rt!=0 && cnt[id_rt]!=0).
  - waw_hazard = id_writes && id_rd!=0 && cnt[id_rd]!=0 && cnt[id_rd] >= id_lat.
- issue = id_valid && !stall && !hold && !flush && id_writes && id_rd!=0 && id_lat!=0.
- Per-edge update, priority rst > flush > hold > normal:
  - rst (async): all cnt = 0.
  - flush: all cnt = 0; no issue.
  - hold: all cnt unchanged; no issue; hazard outputs still evaluated.
  - normal: cnt[id_rd] = id_lat if issue. Every other nonzero cnt decrements by 1. On a simultaneous issue to and decrement of the same register, the issue wins.
- Counters saturate at 0; never wrap below 0.
- busy is a direct decode of the counters.

## Timing
- Reset values: all cnt 0, busy = 0, stall/raw_hazard/waw_hazard = 0.
- Hazard outputs are combinational from ID inputs and registered counters, with no added latency.
- Producer issue at edge N (leaves ID): next instruction sees cnt = L in cycle N+1.
  - It stalls for exactly L cycles, then proceeds in cycle N+1+L.
  - For L=1 this reproduces the single load-use bubble.
- hold cycles extend the stall one-for-one: counters do not advance.
- Reset asserted mid-operation clears everything immediately, without waiting for clk. Deassertion is consumed at the next edge.
- Maximum latency 2**LAT_W-1 (7 by default). Values are taken unmodified.

## Test plan
- Load-use: issue rd=5, lat=1. Next instr reads rs=5 → stall=1 for 1 cycle, then 0. Same pattern with rt=5 → same. An unrelated instr (rs=6, rt=7) → stall=0 throughout.
- Multi-cycle: issue rd=9, lat=4. Dependent reads rt=9 → raw_hazard=1 for 4 cycles. busy[9] is 1 for 4 cycles, then 0.
- Register zero: issue rd=0, lat=3 → busy stays 0. A reader of r0 is never stalled.
- WAW: issue rd=3, lat=4. Next instr writes rd=3 with lat=0 → waw_hazard=1 until cnt[3]=0. The same with lat=5 while cnt[3]=4 → no stall; cnt[3] reloads to 5.
- Hold/flush: issue rd=4, lat=2. Assert hold 3 cycles → busy[4] stays 1 and cnt is frozen. Release → 2 further stall cycles. Separately, flush while cnt[4]=2 → busy=0 next cycle and stall=0 during flush.
- Async reset: assert rst between edges while cnt[8]=3 → busy=0 and stall=0 immediately. After deassertion, a reader of r8 proceeds without stall.
